// File: rtl/priority_encoder.sv
// Captures an 8-bit request vector and emits one beat per set bit, in ascending or
// descending bit order, over a valid/ready output handshake.
module priority_encoder #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] code,
  output logic       last,
  output logic       none
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] sel_idx;
  logic [7:0] sel_mask;
  logic       sel_single;

  // Later loop iterations overwrite earlier ones, so the scan direction picks the winner.
  always_comb begin
    sel_idx = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end
    sel_mask   = 8'h01 << sel_idx;
    sel_single = (pending_q & (pending_q - 8'd1)) == 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pending_d = req;
          state_d   = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          // An all-zero capture has nothing to clear; the single none beat ends the vector.
          pending_d = pending_q & ~sel_mask;
          if (sel_single) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StEmit);
    code      = (state_q == StEmit) ? sel_idx : 3'd0;
    last      = (state_q == StEmit) && sel_single;
    none      = (state_q == StEmit) && (pending_q == 8'h00);
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Directed-vector bench for priority_encoder: one instance per service order, outputs
// sampled on the falling edge, inputs changed on the falling edge.
module tb_priority_encoder;

  logic       clk;
  logic       rst;
  logic       in_valid0, in_ready0, out_valid0, out_ready0, last0, none0;
  logic [7:0] req0;
  logic [2:0] code0;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, last1, none1;
  logic [7:0] req1;
  logic [2:0] code1;

  int n_checks = 0;
  int n_pass   = 0;

  priority_encoder #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .req(req0),
    .out_valid(out_valid0), .out_ready(out_ready0), .code(code0), .last(last0), .none(none0)
  );

  priority_encoder #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .req(req1),
    .out_valid(out_valid1), .out_ready(out_ready1), .code(code1), .last(last1), .none(none1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({in_ready0, out_valid0, code0, last0, none0} !== 7'b1_0_000_0_0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b code=%0d last=%b none=%b want 1 0 0 0 0",
               in_ready0, out_valid0, code0, last0, none0);
    else n_pass++;
    n_checks++;
    if ({in_ready1, out_valid1, code1, last1, none1} !== 7'b1_0_000_0_0)
      $display("FAIL reset_outputs_msb: got rdy=%b vld=%b code=%0d last=%b none=%b want 1 0 0 0 0",
               in_ready1, out_valid1, code1, last1, none1);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    out_ready0 = 1'b1;
    req0       = 8'b0000_0100;
    in_valid0  = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    req0      = 8'hFF;
    n_checks++;
    if ({out_valid0, code0, last0, none0, in_ready0} !== {1'b1, 3'd2, 1'b1, 1'b0, 1'b0})
      $display("FAIL single_beat: got vld=%b code=%0d last=%b none=%b rdy=%b want 1 2 1 0 0",
               out_valid0, code0, last0, none0, in_ready0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({in_ready0, out_valid0} !== 2'b10)
      $display("FAIL single_idle: got rdy=%b vld=%b want 1 0", in_ready0, out_valid0);
    else n_pass++;
  endtask

  task automatic test_multi_lsb();
    logic [2:0] exp_code [3] = '{3'd1, 3'd5, 3'd7};
    logic       exp_last [3] = '{1'b0, 1'b0, 1'b1};
    out_ready0 = 1'b1;
    req0       = 8'b1010_0010;
    in_valid0  = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({out_valid0, code0, last0, none0} !== {1'b1, exp_code[k], exp_last[k], 1'b0})
        $display("FAIL multi_lsb_beat%0d: got vld=%b code=%0d last=%b none=%b want 1 %0d %b 0",
                 k, out_valid0, code0, last0, none0, exp_code[k], exp_last[k]);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({in_ready0, out_valid0} !== 2'b10)
      $display("FAIL multi_lsb_done: got rdy=%b vld=%b want 1 0", in_ready0, out_valid0);
    else n_pass++;
  endtask

  task automatic test_multi_msb();
    logic [2:0] exp_code [3] = '{3'd7, 3'd5, 3'd1};
    logic       exp_last [3] = '{1'b0, 1'b0, 1'b1};
    out_ready1 = 1'b1;
    req1       = 8'b1010_0010;
    in_valid1  = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({out_valid1, code1, last1, none1} !== {1'b1, exp_code[k], exp_last[k], 1'b0})
        $display("FAIL multi_msb_beat%0d: got vld=%b code=%0d last=%b none=%b want 1 %0d %b 0",
                 k, out_valid1, code1, last1, none1, exp_code[k], exp_last[k]);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({in_ready1, out_valid1} !== 2'b10)
      $display("FAIL multi_msb_done: got rdy=%b vld=%b want 1 0", in_ready1, out_valid1);
    else n_pass++;
  endtask

  task automatic test_zero();
    out_ready0 = 1'b1;
    req0       = 8'h00;
    in_valid0  = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    n_checks++;
    if ({out_valid0, code0, last0, none0} !== {1'b1, 3'd0, 1'b1, 1'b1})
      $display("FAIL zero_beat: got vld=%b code=%0d last=%b none=%b want 1 0 1 1",
               out_valid0, code0, last0, none0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({in_ready0, out_valid0, none0} !== 3'b100)
      $display("FAIL zero_done: got rdy=%b vld=%b none=%b want 1 0 0", in_ready0, out_valid0, none0);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic       pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int         beats = 0;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_code = 3'd0;
    out_ready0 = 1'b0;
    req0       = 8'hFF;
    in_valid0  = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid0 !== 1'b1) break;
      n_checks++;
      if (in_ready0 !== 1'b0)
        $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready0);
      else n_pass++;
      n_checks++;
      if ({code0, last0} !== {beats[2:0], beats == 7})
        $display("FAIL stall_beat c%0d: got code=%0d last=%b want %0d %b",
                 c, code0, last0, beats, beats == 7);
      else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if (code0 !== prev_code)
          $display("FAIL stall_hold c%0d: got code=%0d want %0d", c, code0, prev_code);
        else n_pass++;
      end
      out_ready0 = pattern[c % 4];
      if (out_ready0) beats++;
      prev_code  = code0;
      prev_stall = !out_ready0;
      @(negedge clk);
    end
    n_checks++;
    if (beats != 8 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1)
      $display("FAIL stall_count: got beats=%0d vld=%b rdy=%b want 8 0 1",
               beats, out_valid0, in_ready0);
    else n_pass++;
    out_ready0 = 1'b1;
  endtask

  task automatic test_back_to_back();
    out_ready0 = 1'b1;
    req0       = 8'h03;
    in_valid0  = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid0, code0, last0} !== {1'b1, 3'd1, 1'b1})
      $display("FAIL b2b_second: got vld=%b code=%0d last=%b want 1 1 1", out_valid0, code0, last0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (in_ready0 !== 1'b1)
      $display("FAIL b2b_ready: got %b want 1", in_ready0);
    else n_pass++;
    req0      = 8'h80;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    n_checks++;
    if ({out_valid0, code0, last0, none0} !== {1'b1, 3'd7, 1'b1, 1'b0})
      $display("FAIL b2b_next: got vld=%b code=%0d last=%b none=%b want 1 7 1 0",
               out_valid0, code0, last0, none0);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    out_ready0 = 1'b1;
    req0       = 8'h0F;
    in_valid0  = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid0, code0} !== {1'b1, 3'd2})
      $display("FAIL midrst_pre: got vld=%b code=%0d want 1 2", out_valid0, code0);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid0, in_ready0, code0, last0, none0} !== 7'b0_1_000_0_0)
      $display("FAIL midrst_async: got vld=%b rdy=%b code=%0d last=%b none=%b want 0 1 0 0 0",
               out_valid0, in_ready0, code0, last0, none0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid0 !== 1'b0)
      $display("FAIL midrst_abandon: got vld=%b want 0", out_valid0);
    else n_pass++;
    req0      = 8'h01;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    n_checks++;
    if ({out_valid0, code0, last0, none0} !== {1'b1, 3'd0, 1'b1, 1'b0})
      $display("FAIL midrst_after: got vld=%b code=%0d last=%b none=%b want 1 0 1 0",
               out_valid0, code0, last0, none0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({in_ready0, out_valid0} !== 2'b10)
      $display("FAIL midrst_done: got rdy=%b vld=%b want 1 0", in_ready0, out_valid0);
    else n_pass++;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid0  = 1'b0;
    req0       = 8'h00;
    out_ready0 = 1'b0;
    in_valid1  = 1'b0;
    req1       = 8'h00;
    out_ready1 = 1'b0;
    test_reset();
    test_single();
    test_multi_lsb();
    test_multi_msb();
    test_zero();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
